// File: rtl/adder_seq_pkg.sv
// Shared types for the chunked sequential adder.
// FSM states and NZCV flag bit positions.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder
// built from one full-adder cell per bit.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[CHUNK];

endmodule

// File: rtl/adder_nbits_seq.sv
// Multi-cycle N-bit adder, CHUNK bits per clock,
// valid/ready on both sides, NZCV flags on completion.
module adder_nbits_seq
  import adder_seq_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic            Cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] R,
  output logic            Cout,
  output logic [3:0]      flags
);

  localparam int NCHUNK = BITS / CHUNK;
  localparam int CW     = $clog2(NCHUNK);

  state_t          r_state;
  state_t          w_next;
  logic [BITS-1:0] r_a;
  logic [BITS-1:0] r_b;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic            r_amsb;
  logic            r_bmsb;

  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_last;
  logic             w_accept;
  logic [BITS-1:0]  w_rfin;
  logic [3:0]       w_flags;

  assign in_ready  = (r_state == IDLE) & ~rst;
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_cnt == CW'(NCHUNK - 1));

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (r_a[r_cnt*CHUNK +: CHUNK]),
    .b    (r_b[r_cnt*CHUNK +: CHUNK]),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout)
  );

  // Top chunk lands last, so the full result is known on that edge
  assign w_rfin = {w_sum, R[BITS-CHUNK-1:0]};

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_N] = w_sum[CHUNK-1];
    w_flags[FLAG_Z] = (w_rfin == '0);
    w_flags[FLAG_C] = w_cout;
    w_flags[FLAG_V] = (r_amsb == r_bmsb) &
                      (w_sum[CHUNK-1] != r_amsb);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = BUSY;
      BUSY:    if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      R       <= '0;
      Cout    <= 1'b0;
      flags   <= '0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_carry <= Cin;
      r_cnt   <= '0;
      r_amsb  <= A[BITS-1];
      r_bmsb  <= B[BITS-1];
    end else if (r_state == BUSY) begin
      R[r_cnt*CHUNK +: CHUNK] <= w_sum;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        Cout  <= w_cout;
        flags <= w_flags;
      end
    end
  end

endmodule

// File: doc/adder_nbits_seq.md
Name: adder_nbits_seq

Overview:
- Multi-cycle N-bit adder computing R = A + B + Cin.
- Complement of the team's ripple-borrow subtractor: it uses a carry chain, processed CHUNK bits per clock rather than fully combinationally.
- Sits between the ALU issue logic and the result/flag writeback. Exchanges data with a valid/ready handshake on both sides.
- Produces ARMv4-style NZCV flags for the addition.

Parameters:
- BITS, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits added per clock cycle; NCHUNK = BITS/CHUNK, NCHUNK >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands A, B and Cin are valid.
- in_ready  output  1  block accepts operands this cycle.
- A  input  BITS  augend.
- B  input  BITS  addend.
- Cin  input  1  carry in.
- out_valid  output  1  R and flags are valid.
- out_ready  input  1  consumer takes the result.
- R  output  BITS  sum.
- Cout  output  1  carry out of bit BITS-1.
- flags  output  4  {N,Z,C,V}.

Behaviour:
- Interface: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, R=0, Cout=0, flags=0, out_valid=0, chunk counter=0, carry register=0. in_ready=0 while rst is high.
- States are IDLE, BUSY and DONE.
- in_ready = (state==IDLE) & ~rst.
- out_valid = (state==DONE).
- Accept: on an edge with in_valid & in_ready:
  - latch A, B;
  - carry reg := Cin;
  - count := 0;
  - store A[BITS-1] and B[BITS-1] for V;
  - state := BUSY.
- BUSY, each edge:
  - add chunk[count] of A and B plus carry reg;
  - write the CHUNK sum bits into R[count*CHUNK +: CHUNK];
  - carry reg := chunk carry out;
  - count++.
  - On the edge where count==NCHUNK-1, state := DONE and Cout/flags are registered from the final chunk.
- Latency: out_valid is high exactly NCHUNK edges after the accept edge. Default is 4.
- Flags:
  - N = R[BITS-1].
  - Z = (R==0).
  - C = Cout.
  - V = (A_msb==B_msb) & (R[BITS-1]!=A_msb).
- DONE:
  - R, Cout and flags are held stable while out_valid & ~out_ready, for any number of cycles.
  - On an edge with out_ready, state := IDLE.
  - in_ready stays 0 in DONE: there is no same-cycle accept on the result handoff. Minimum issue interval is NCHUNK+2 cycles.
- Input changes in BUSY/DONE are ignored; operands are captured only at accept.
- R holds its last value in IDLE, not cleared. Partially written R during BUSY is not observable as valid.
- rst asserted mid-operation:
  - immediate return to reset values, and the in-flight operation is discarded;
  - first accept is possible on the first edge after rst deasserts.
- Carry wraps out of the top bit into Cout only; R is modulo 2^BITS.

Decomposition:
- Package adder_seq_pkg:
  - state enum typedef (IDLE, BUSY, DONE);
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module adder_chunk: combinational CHUNK-bit ripple-carry adder built from full-adder cells. Inputs a, b, cin; outputs s, cout. Instantiated once and indexed by the counter.
- Top-level module holds the FSM, counter, operand and result registers, and flag logic.

Test Plan:
- Basic sum: A=0x00000001, B=0x00000002, Cin=0 -> R=0x00000003, flags=0000. out_valid is high exactly 4 edges after accept.
- Full-width carry: A=0xFFFFFFFF, B=0x00000001, Cin=0 -> R=0x00000000, Cout=1, flags N0 Z1 C1 V0. Carry crosses all chunk boundaries.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001 -> R=0x80000000, flags N1 Z0 C0 V1. Also A=0x80000000, B=0x80000000 -> R=0, flags 0111.
- Cin at chunk boundary: A=0x000000FF, B=0, Cin=1 -> R=0x00000100, C0 V0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required:
  - R, flags and out_valid stay constant and in_ready=0;
  - in_valid toggled with new operands has no effect;
  - after out_ready=1 for one edge, in_ready=1 the next cycle.
- Reset mid-op: assert rst after 2 BUSY edges. Required:
  - outputs go to 0 immediately, without waiting for a clock edge;
  - after release, in_ready=1;
  - A=0x12345678, B=0x11111111 -> R=0x23456789, flags 0000.
